// File: rtl/cnn_pkg.sv
// Shared definitions for the binary CNN pooling front end.
//   - Default feature-map geometry and derived pooled-output geometry.
//   - State type for the 2x2 window builder.
package cnn_pkg;

    localparam int IMG_W_DEF  = 24;
    localparam int IMG_H_DEF  = 24;
    localparam int POOL_W_DEF = IMG_W_DEF / 2;
    localparam int POOL_H_DEF = IMG_H_DEF / 2;

    typedef enum logic [1:0] {
        EVEN_ROW,
        ODD_ROW,
        DONE
    } win_state_t;

endpackage

// File: rtl/line_buf_1b.sv
// One-line, 1-bit-wide pixel buffer.
//   clk              : write clock
//   we/waddr/wdata   : synchronous write port
//   raddr_a/rdata_a  : combinational read port A
//   raddr_b/rdata_b  : combinational read port B
// Contents are not reset; every location is written before it is read.
module line_buf_1b #(
    parameter int DEPTH = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic          rdata_a,
    output logic          rdata_b
);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/maxpool_window_buf.sv
// Builds non-overlapping stride-2 2x2 windows from a raster-order stream of
// binary pixels and presents them to the max-pool stage.
//   clk, rst       : clock, synchronous active-high reset
//   valid_in       : pixel_in valid (no backpressure)
//   sof_in         : with valid_in, marks pixel (0,0) of a frame
//   pixel_in       : binary input pixel
//   valid_out_buf  : one-cycle pulse, window on pixel_0..3 valid
//   pixel_0..3     : top-left, top-right, bottom-left, bottom-right
//   win_col/win_row: output-grid coordinates of the window
//   frame_done     : pulses together with the last window of a frame
module maxpool_window_buf
    import cnn_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int COL_W = $clog2(IMG_W),
    parameter int ROW_W = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             sof_in,
    input  logic             pixel_in,
    output logic             valid_out_buf,
    output logic             pixel_0,
    output logic             pixel_1,
    output logic             pixel_2,
    output logic             pixel_3,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
    output logic             frame_done
);

    localparam logic [COL_W-1:0] LAST_COL     = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_ODD_COL = COL_W'(2 * (IMG_W / 2) - 1);
    localparam logic [ROW_W-1:0] LAST_ODD_ROW = ROW_W'(2 * (IMG_H / 2) - 1);

    win_state_t       state, state_nxt, eff_state;
    logic [COL_W-1:0] col, col_nxt, eff_col;
    logic [ROW_W-1:0] row, row_nxt, eff_row;
    logic             hold;
    logic             hold_en;
    logic             lb_we;
    logic             emit;
    logic             last_win;
    logic             row_used;
    logic             lb_rd_a;
    logic             lb_rd_b;

    // sof_in forces the pixel to (0,0) with a fresh FSM, so all decode below
    // works on these effective values rather than the stored ones.
    always_comb begin
        eff_state = sof_in ? EVEN_ROW : state;
        eff_col   = sof_in ? '0 : col;
        eff_row   = sof_in ? '0 : row;
    end

    line_buf_1b #(
        .DEPTH(IMG_W),
        .AW   (COL_W)
    ) u_line_buf (
        .clk    (clk),
        .we     (lb_we),
        .waddr  (eff_col),
        .wdata  (pixel_in),
        .raddr_a(eff_col & ~COL_W'(1)),
        .raddr_b(eff_col),
        .rdata_a(lb_rd_a),
        .rdata_b(lb_rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EVEN_ROW;
            col   <= '0;
            row   <= '0;
            hold  <= 1'b0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            if (hold_en) begin
                hold <= pixel_in;
            end
        end
    end

    always_comb begin
        state_nxt = (state == DONE) ? EVEN_ROW : state;
        col_nxt   = col;
        row_nxt   = row;
        lb_we     = 1'b0;
        hold_en   = 1'b0;
        emit      = 1'b0;
        last_win  = 1'b0;
        // Rows past the last odd row (odd IMG_H) are swallowed silently.
        row_used  = (eff_row <= LAST_ODD_ROW);

        if (valid_in) begin
            if (eff_col == LAST_COL) begin
                col_nxt = '0;
                row_nxt = (eff_row == LAST_ROW) ? '0 : eff_row + ROW_W'(1);
            end else begin
                col_nxt = eff_col + COL_W'(1);
                row_nxt = eff_row;
            end

            unique case (eff_state)
                ODD_ROW: begin
                    if (!eff_col[0]) begin
                        hold_en = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        last_win = (eff_row == LAST_ODD_ROW) && (eff_col == LAST_ODD_COL);
                    end
                    if (eff_col == LAST_COL) begin
                        state_nxt = (eff_row == LAST_ODD_ROW) ? DONE : EVEN_ROW;
                    end else begin
                        state_nxt = ODD_ROW;
                    end
                end
                // DONE takes a pixel exactly like an even row.
                default: begin
                    lb_we = row_used;
                    if (eff_col == LAST_COL) begin
                        state_nxt = (eff_row == LAST_ROW) ? EVEN_ROW : ODD_ROW;
                    end else begin
                        state_nxt = EVEN_ROW;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_buf <= 1'b0;
            pixel_0       <= 1'b0;
            pixel_1       <= 1'b0;
            pixel_2       <= 1'b0;
            pixel_3       <= 1'b0;
            win_col       <= '0;
            win_row       <= '0;
            frame_done    <= 1'b0;
        end else begin
            valid_out_buf <= emit;
            pixel_0       <= emit & lb_rd_a;
            pixel_1       <= emit & lb_rd_b;
            pixel_2       <= emit & hold;
            pixel_3       <= emit & pixel_in;
            win_col       <= emit ? (eff_col >> 1) : '0;
            win_row       <= emit ? (eff_row >> 1) : '0;
            frame_done    <= last_win;
        end
    end

endmodule

// File: tb/tb_maxpool_window_buf.sv
// Scoreboard bench for maxpool_window_buf. One input stream drives three
// instances (4x4, 24x24, 5x5); each has a frame-image reference model that
// pushes expected windows and a monitor that pops and compares them.
module tb_maxpool_window_buf;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst, valid_in, sof_in, pixel_in;
    logic mon_en;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] win;
        int         wr;
        int         wc;
        logic       fd;
        time        t;
    } exp_t;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W  = (g == 0) ? 4 : (g == 1) ? IMG_W_DEF : 5;
        localparam int H  = (g == 0) ? 4 : (g == 1) ? IMG_H_DEF : 5;
        localparam int CW = $clog2(W);
        localparam int RW = $clog2(H);

        logic          vout, p0, p1, p2, p3, fd;
        logic [CW-1:0] wcol;
        logic [RW-1:0] wrow;
        exp_t          q[$];
        int unsigned   obs_cnt = 0;

        maxpool_window_buf #(
            .IMG_W(W),
            .IMG_H(H)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .valid_in     (valid_in),
            .sof_in       (sof_in),
            .pixel_in     (pixel_in),
            .valid_out_buf(vout),
            .pixel_0      (p0),
            .pixel_1      (p1),
            .pixel_2      (p2),
            .pixel_3      (p3),
            .win_col      (wcol),
            .win_row      (wrow),
            .frame_done   (fd)
        );

        // Reference: linear position within the frame -> (row, col); keep
        // the frame image and cut a 2x2 window at every odd/odd position
        // that lies inside the even-sized part of the frame.
        initial begin : model
            int   p;
            int   r;
            int   c;
            logic img [24][24];
            exp_t e;
            p = 0;
            forever begin
                @(posedge clk);
                if (rst) begin
                    p = 0;
                end else if (valid_in) begin
                    if (sof_in) p = 0;
                    r = p / W;
                    c = p % W;
                    img[r][c] = pixel_in;
                    if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (H / 2)) && (c < 2 * (W / 2))) begin
                        e.win = {img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c]};
                        e.wr  = r / 2;
                        e.wc  = c / 2;
                        e.fd  = (r == 2 * (H / 2) - 1) && (c == 2 * (W / 2) - 1);
                        e.t   = $time;
                        q.push_back(e);
                    end
                    p = (p + 1) % (W * H);
                end
            end
        end

        initial begin : monitor
            exp_t e;
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    n_checks++;
                    if (vout === 1'b1) begin
                        obs_cnt++;
                        if (q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_window cfg%0d t=%0t: got win=%b row=%0d col=%0d fd=%b, required no window",
                                     g, $time, {p0, p1, p2, p3}, wrow, wcol, fd);
                        end else begin
                            e = q.pop_front();
                            if ({p0, p1, p2, p3} !== e.win || int'(wrow) != e.wr || int'(wcol) != e.wc ||
                                fd !== e.fd || $time != e.t + 5) begin
                                n_fail++;
                                $display("FAIL window cfg%0d: got win=%b row=%0d col=%0d fd=%b t=%0t, required win=%b row=%0d col=%0d fd=%b t=%0t",
                                         g, {p0, p1, p2, p3}, wrow, wcol, fd, $time, e.win, e.wr, e.wc, e.fd, e.t + 5);
                            end
                        end
                    end else if (vout !== 1'b0 || {p0, p1, p2, p3, fd} !== 5'b0 || wcol !== '0 || wrow !== '0) begin
                        n_fail++;
                        $display("FAIL idle_outputs cfg%0d t=%0t: got v=%b win=%b fd=%b row=%0d col=%0d, required all 0",
                                 g, $time, vout, {p0, p1, p2, p3}, fd, wrow, wcol);
                    end
                end
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic s, input logic p);
        rst      = r;
        valid_in = v;
        sof_in   = s;
        pixel_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_count(input string name, input int unsigned got, input int unsigned req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d windows, required %0d", name, got, req);
        end
    endtask

    initial begin
        logic [15:0] pat;
        int unsigned base0, base1, base2;

        rst = 1'b1; valid_in = 1'b0; sof_in = 1'b0; pixel_in = 1'b0; mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Directed 4x4 frame: rows 1000 / 0000 / 0100 / 0010.
        pat   = 16'b1000_0000_0100_0010;
        base0 = g_cfg[0].obs_cnt;
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, i == 0, pat[15-i]);
        idle(3);
        check_count("directed_4x4_count", g_cfg[0].obs_cnt - base0, 4);

        // Ten idle cycles between the bottom-left and bottom-right pixels.
        for (int i = 0; i < 16; i++) begin
            if (i == 5) idle(10);
            drive(1'b0, 1'b1, i == 0, 1'($urandom_range(0, 1)));
        end
        idle(3);

        // sof_in reasserted at the 9th pixel of a 4x4 frame.
        base0 = g_cfg[0].obs_cnt;
        for (int i = 0; i < 24; i++) drive(1'b0, 1'b1, (i == 0) || (i == 8), 1'($urandom_range(0, 1)));
        idle(3);
        check_count("sof_restart_count", g_cfg[0].obs_cnt - base0, 6);

        // Reset together with the pixel that would complete a window.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, i == 0, 1'($urandom_range(0, 1)));
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({g_cfg[0].vout, g_cfg[0].p0, g_cfg[0].p1, g_cfg[0].p2, g_cfg[0].p3, g_cfg[0].fd} !== 6'b0 ||
            g_cfg[0].wcol !== '0 || g_cfg[0].wrow !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b fd=%b, required 0", g_cfg[0].vout, g_cfg[0].fd);
        end
        base0 = g_cfg[0].obs_cnt;
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        idle(3);
        check_count("post_reset_frame_count", g_cfg[0].obs_cnt - base0, 4);

        // All-ones stream: two 5x5 frames back to back, second without sof.
        base2 = g_cfg[2].obs_cnt;
        for (int i = 0; i < 50; i++) drive(1'b0, 1'b1, i == 0, 1'b1);
        idle(3);
        check_count("odd_5x5_count", g_cfg[2].obs_cnt - base2, 8);

        // Two random 24x24 frames with ~30% idle gaps.
        base1 = g_cfg[1].obs_cnt;
        for (int i = 0; i < 2 * IMG_W_DEF * IMG_H_DEF; i++) begin
            while ($urandom_range(0, 99) < 30) drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            drive(1'b0, 1'b1, i == 0, 1'($urandom_range(0, 1)));
        end
        idle(5);
        check_count("random_24x24_count", g_cfg[1].obs_cnt - base1, 2 * POOL_W_DEF * POOL_H_DEF);

        check_count("cfg0_leftover", g_cfg[0].q.size(), 0);
        check_count("cfg1_leftover", g_cfg[1].q.size(), 0);
        check_count("cfg2_leftover", g_cfg[2].q.size(), 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
